// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory-port arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [1:0]  mem_ctrl_t;

    // NONE must stay encoding 0: it is what the core drives on an idle port.
    localparam mem_ctrl_t MEM_CTRL_NONE  = 2'd0;
    localparam mem_ctrl_t MEM_CTRL_READ  = 2'd1;
    localparam mem_ctrl_t MEM_CTRL_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searching upward from last+1 with wrap
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_pick,
    output logic             o_any_valid
);

    // Walk the candidates from farthest to nearest so the nearest valid one wins.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_idx       = '0;
        o_pick      = '0;
        o_any_valid = |i_valid;
        for (int k = N; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last) + k) % N);
            if (i_valid[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory port among N_REQ requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  mem_ctrl_t [N_REQ-1:0] req_ctrl,
    input  word_t [N_REQ-1:0]     req_addr,
    input  word_t [N_REQ-1:0]     req_din,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output word_t                 resp_data,
    output mem_ctrl_t             mem_ctrl,
    output word_t                 mem_addr,
    output word_t                 mem_din,
    input  word_t                 mem_dout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    mem_arb_state_t   r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    mem_ctrl_t        r_mem_ctrl;
    word_t            r_mem_addr;
    word_t            r_mem_din;
    logic [N_REQ-1:0] r_resp_valid;
    word_t            r_resp_data;

    logic [IDX_W-1:0] w_pick;
    logic             w_any_valid;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_valid     (req_valid),
        .i_last      (r_last_grant),
        .o_pick      (w_pick),
        .o_any_valid (w_any_valid)
    );

    // Accept is combinational so a requester sees ready in the same cycle as its valid.
    always_comb begin
        req_ready = '0;
        if (rst && (r_state == IDLE) && w_any_valid) begin
            req_ready[w_pick] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_cnt        <= '0;
            r_mem_ctrl   <= MEM_CTRL_NONE;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_grant    <= w_pick;
                        r_mem_ctrl <= req_ctrl[w_pick];
                        r_mem_addr <= req_addr[w_pick];
                        r_mem_din  <= req_din[w_pick];
                        r_cnt      <= CNT_W'(MEM_LATENCY - 1);
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes also complete here; their captured data is meaningless to the requester.
                    if (r_cnt == '0) begin
                        r_resp_data           <= mem_dout;
                        r_mem_ctrl            <= MEM_CTRL_NONE;
                        r_resp_valid[r_grant] <= 1'b1;
                        r_state               <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[r_grant]) begin
                        r_resp_valid <= '0;
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign mem_ctrl   = r_mem_ctrl;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;

endmodule
